// File: rtl/mem_arbiter.sv
// Round-robin sequencer sharing one multi-cycle single-port memory between
// the fetch stage and the memory stage.
module mem_arbiter #(
  parameter int unsigned LATENCY = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IReq,
  input  logic [31:0] IAddr,
  output logic [31:0] IRD,
  output logic        IReady,
  input  logic        DReq,
  input  logic        DWE,
  input  logic [31:0] DAddr,
  input  logic [31:0] DWD,
  output logic [31:0] DRD,
  output logic        DReady,
  output logic [31:0] MemA,
  output logic [31:0] MemWD,
  output logic        MemWE,
  input  logic [31:0] MemRD
);

  localparam int unsigned CntW = 4;
  localparam logic OwnI = 1'b0;
  localparam logic OwnD = 1'b1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} stateT;

  stateT           state;
  logic [CntW-1:0] cnt;
  logic            owner;
  logic            lw;
  logic            weQ;

  logic eligI;
  logic eligD;
  logic grant;
  logic winD;

  // Grant decision; in DONE the current owner is still requesting and is masked.
  always_comb begin
    eligI = IReq;
    eligD = DReq;
    if (state == DONE) begin
      if (owner == OwnD) eligD = 1'b0;
      else               eligI = 1'b0;
    end
    grant = eligI | eligD;
    winD  = eligD & (~eligI | (lw == OwnI));
  end

  // MemA/MemWD double as the latched transaction address and write data.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      cnt    <= '0;
      owner  <= OwnI;
      lw     <= OwnI;
      weQ    <= 1'b0;
      IRD    <= '0;
      DRD    <= '0;
      IReady <= 1'b0;
      DReady <= 1'b0;
      MemA   <= '0;
      MemWD  <= '0;
    end else begin
      IReady <= 1'b0;
      DReady <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (grant) begin
            owner <= winD;
            lw    <= winD;
            MemA  <= winD ? DAddr : IAddr;
            if (winD) MemWD <= DWD;
            weQ   <= winD & DWE;
            cnt   <= CntW'(LATENCY - 1);
            state <= ACCESS;
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            if (owner == OwnD) begin
              DRD    <= MemRD;
              DReady <= 1'b1;
            end else begin
              IRD    <= MemRD;
              IReady <= 1'b1;
            end
            state <= DONE;
          end else begin
            cnt <= cnt - CntW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write strobe only in the last access cycle: one write edge per store.
  assign MemWE = (state == ACCESS) && (cnt == '0) && weQ;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: LATENCY=2 and LATENCY=1 builds,
// each backed by a small behavioural memory.
module tb_mem_arbiter;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic        IReq0, DReq0, DWE0;
  logic [31:0] IAddr0, DAddr0, DWD0;
  logic [31:0] IRD0, DRD0, MemA0, MemWD0, MemRD0;
  logic        IReady0, DReady0, MemWE0;

  logic        IReq1, DReq1, DWE1;
  logic [31:0] IAddr1, DAddr1, DWD1;
  logic [31:0] IRD1, DRD1, MemA1, MemWD1, MemRD1;
  logic        IReady1, DReady1, MemWE1;

  mem_arbiter #(.LATENCY(2)) dut0 (
    .CLK(CLK), .RST(RST),
    .IReq(IReq0), .IAddr(IAddr0), .IRD(IRD0), .IReady(IReady0),
    .DReq(DReq0), .DWE(DWE0), .DAddr(DAddr0), .DWD(DWD0), .DRD(DRD0), .DReady(DReady0),
    .MemA(MemA0), .MemWD(MemWD0), .MemWE(MemWE0), .MemRD(MemRD0)
  );

  mem_arbiter #(.LATENCY(1)) dut1 (
    .CLK(CLK), .RST(RST),
    .IReq(IReq1), .IAddr(IAddr1), .IRD(IRD1), .IReady(IReady1),
    .DReq(DReq1), .DWE(DWE1), .DAddr(DAddr1), .DWD(DWD1), .DRD(DRD1), .DReady(DReady1),
    .MemA(MemA1), .MemWD(MemWD1), .MemWE(MemWE1), .MemRD(MemRD1)
  );

  logic [31:0] mem0 [0:255];
  logic [31:0] mem1 [0:255];
  logic        pokeEn, pokeSel;
  logic [7:0]  pokeIdx;
  logic [31:0] pokeData;

  always @(posedge CLK) begin
    if (MemWE0) mem0[MemA0[9:2]] <= MemWD0;
    else if (pokeEn && !pokeSel) mem0[pokeIdx] <= pokeData;
    if (MemWE1) mem1[MemA1[9:2]] <= MemWD1;
    else if (pokeEn && pokeSel) mem1[pokeIdx] <= pokeData;
  end

  assign MemRD0 = mem0[MemA0[9:2]];
  assign MemRD1 = mem1[MemA1[9:2]];

  logic sel;
  logic rIReady, rDReady, rWE;
  assign rIReady = sel ? IReady1 : IReady0;
  assign rDReady = sel ? DReady1 : DReady0;
  assign rWE     = sel ? MemWE1  : MemWE0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic s, input logic [31:0] a, input logic [31:0] d);
    pokeSel  = s;
    pokeIdx  = 8'(a >> 2);
    pokeData = d;
    pokeEn   = 1'b1;
    @(posedge CLK);
    #1 pokeEn = 1'b0;
  endtask

  // Called in cycle 0 of a request; returns the cycle index of the Ready pulse.
  task automatic waitOne(input bit isD, output int rdyCyc, output int weCnt,
                         output int weFirst, output int overlap);
    rdyCyc = -1; weCnt = 0; weFirst = -1; overlap = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (rWE) begin
        weCnt++;
        if (weFirst < 0) weFirst = k;
      end
      if (isD ? rIReady : rDReady) overlap++;
      if (isD ? rDReady : rIReady) begin
        rdyCyc = k;
        break;
      end
    end
  endtask

  int rc, wc, wf, ov;
  int nRdy, both;
  logic [31:0] who [4];
  int          cyc [4];
  logic [31:0] expWho [4];
  int          expCyc [4];

  initial begin
    RST = 1'b1; sel = 1'b0; pokeEn = 1'b0; pokeSel = 1'b0; pokeIdx = '0; pokeData = '0;
    IReq0 = 0; DReq0 = 0; DWE0 = 0; IAddr0 = '0; DAddr0 = '0; DWD0 = '0;
    IReq1 = 0; DReq1 = 0; DWE1 = 0; IAddr1 = '0; DAddr1 = '0; DWD1 = '0;
    expWho = '{32'd1, 32'd0, 32'd1, 32'd0};
    expCyc = '{3, 6, 9, 12};

    poke(1'b0, 32'h100, 32'h2002000A);
    poke(1'b0, 32'h40,  32'h11111111);
    poke(1'b0, 32'h80,  32'h0BADF00D);
    poke(1'b1, 32'h0,   32'hA5A50000);
    poke(1'b1, 32'h4,   32'h00000000);

    // reset values
    @(negedge CLK);
    chk("rst_ird", IRD0, 32'h0);
    chk("rst_drd", DRD0, 32'h0);
    chk("rst_iready", 32'(IReady0), 32'h0);
    chk("rst_dready", 32'(DReady0), 32'h0);
    chk("rst_mema", MemA0, 32'h0);
    chk("rst_memwd", MemWD0, 32'h0);
    chk("rst_memwe", 32'(MemWE0), 32'h0);
    chk("rst_ird1", IRD1, 32'h0);
    @(posedge CLK); #1 RST = 1'b0;

    // single fetch
    @(posedge CLK); #1 IAddr0 = 32'h100; IReq0 = 1'b1;
    waitOne(1'b0, rc, wc, wf, ov);
    chk("fetch_cycle", 32'(rc), 32'd3);
    chk("fetch_ird", IRD0, 32'h2002000A);
    chk("fetch_dready", 32'(ov), 32'd0);
    chk("fetch_we", 32'(wc), 32'd0);

    // store then load, same requester
    @(posedge CLK); #1 IReq0 = 1'b0;
    DReq0 = 1'b1; DWE0 = 1'b1; DAddr0 = 32'h80; DWD0 = 32'h12345678;
    @(negedge CLK);
    chk("fetch_pulse_width", 32'(IReady0), 32'd0);
    waitOne(1'b1, rc, wc, wf, ov);
    chk("store_cycle", 32'(rc), 32'd2);
    // The extra negedge above consumed cycle 0, so Ready sits at local cycle 2.
    chk("store_we_cnt", 32'(wc), 32'd1);
    chk("store_we_cycle", 32'(wf), 32'd1);
    chk("store_mem", mem0[8'h20], 32'h12345678);
    @(posedge CLK); #1 DWE0 = 1'b0;
    waitOne(1'b1, rc, wc, wf, ov);
    chk("load_cycle", 32'(rc), 32'd3);
    chk("load_drd", DRD0, 32'h12345678);
    chk("load_we", 32'(wc), 32'd0);
    @(posedge CLK); #1 DReq0 = 1'b0;

    // reset one cycle before the store's write cycle
    @(posedge CLK); #1 DReq0 = 1'b1; DWE0 = 1'b1; DAddr0 = 32'h40; DWD0 = 32'hDEADBEEF;
    @(posedge CLK);
    @(negedge CLK);
    chk("pre_rst_mema", MemA0, 32'h40);
    RST = 1'b1;
    #1;
    chk("arst_ird", IRD0, 32'h0);
    chk("arst_drd", DRD0, 32'h0);
    chk("arst_mema", MemA0, 32'h0);
    chk("arst_memwd", MemWD0, 32'h0);
    chk("arst_memwe", 32'(MemWE0), 32'h0);
    chk("arst_dready", 32'(DReady0), 32'h0);
    DReq0 = 1'b0; DWE0 = 1'b0;
    @(posedge CLK); @(posedge CLK); #1 RST = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("post_rst_we", 32'(MemWE0), 32'h0);
      chk("post_rst_dready", 32'(DReady0), 32'h0);
    end
    chk("arst_mem_kept", mem0[8'h10], 32'h11111111);

    // simultaneous requests after reset, then sustained contention
    @(posedge CLK); #1 IAddr0 = 32'h100; IReq0 = 1'b1; DAddr0 = 32'h80; DWE0 = 1'b0; DReq0 = 1'b1;
    nRdy = 0; both = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge CLK);
      if (IReady0 && DReady0) both++;
      if (IReady0 || DReady0) begin
        if (nRdy < 4) begin
          who[nRdy] = DReady0 ? 32'd1 : 32'd0;
          cyc[nRdy] = k;
        end
        nRdy++;
        if (DReady0) chk("rr_drd", DRD0, 32'h12345678);
        else         chk("rr_ird", IRD0, 32'h2002000A);
      end
      @(posedge CLK); #1;
      if (k == 9)  DReq0 = 1'b0;
      if (k == 12) IReq0 = 1'b0;
    end
    chk("rr_count", 32'(nRdy), 32'd4);
    chk("rr_overlap", 32'(both), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr_who%0d", i), who[i], expWho[i]);
      chk($sformatf("rr_cyc%0d", i), 32'(cyc[i]), 32'(expCyc[i]));
    end

    // LATENCY=1 instance
    sel = 1'b1;
    @(posedge CLK); #1 IAddr1 = 32'h0; IReq1 = 1'b1;
    waitOne(1'b0, rc, wc, wf, ov);
    chk("l1_fetch_cycle", 32'(rc), 32'd2);
    chk("l1_fetch_ird", IRD1, 32'hA5A50000);
    @(posedge CLK); #1 IReq1 = 1'b0;
    DReq1 = 1'b1; DWE1 = 1'b1; DAddr1 = 32'h4; DWD1 = 32'hCAFEF00D;
    waitOne(1'b1, rc, wc, wf, ov);
    chk("l1_store_cycle", 32'(rc), 32'd2);
    chk("l1_store_we_cnt", 32'(wc), 32'd1);
    chk("l1_store_we_cycle", 32'(wf), 32'd1);
    @(posedge CLK); #1 DWE1 = 1'b0;
    waitOne(1'b1, rc, wc, wf, ov);
    chk("l1_load_cycle", 32'(rc), 32'd2);
    chk("l1_load_drd", DRD1, 32'hCAFEF00D);
    chk("l1_load_we", 32'(wc), 32'd0);
    @(posedge CLK); #1 DReq1 = 1'b0;
    @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
